// File: rtl/fhe_add_sched.sv
// fhe_add_sched: round-robin scheduler running byte-serial NBYTES-wide adds on one shared external 8-bit adder slice.
// Define FHE_ADD_SCHED_SUB_EN to add a per-requester req_sub port (A-B via inverted B and carry-in 1).
module fhe_add_sched #(
    parameter int NREQ = 4,
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES,
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1,
    localparam int XW = NBYTES > 1 ? $clog2(NBYTES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
`ifdef FHE_ADD_SCHED_SUB_EN
    input  logic [NREQ-1:0]   req_sub,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [IW-1:0]     rsp_id,
    output logic [7:0]        add_a,
    output logic [7:0]        add_b,
    output logic              add_cin,
    input  logic [7:0]        add_sum,
    input  logic              add_cout
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, gnt;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [XW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d, cout_q, cout_d, found, sub, last;
    int            j;

    // Descending scan so the lowest offset from rr_ptr wins
    always_comb begin
        gnt = '0;
        found = 1'b0;
        j = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            j = j >= NREQ ? j - NREQ : j;
            if (req_valid[IW'(j)]) begin
                gnt = IW'(j);
                found = 1'b1;
            end
        end
    end

`ifdef FHE_ADD_SCHED_SUB_EN
    assign sub = req_sub[gnt];
`else
    assign sub = 1'b0;
`endif
    assign last = idx_q == XW'(NBYTES - 1);

    // B is stored pre-inverted for subtraction so RUN never needs the mode bit
    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d = id_q;
        a_d = a_q;
        b_d = b_q;
        sum_d = sum_q;
        idx_d = idx_q;
        carry_d = carry_q;
        cout_d = cout_q;
        req_ready = '0;
        add_a = '0;
        add_b = '0;
        add_cin = 1'b0;
        if (state_q == IDLE && found) begin
            req_ready = NREQ'(1) << gnt;
            a_d = req_a[gnt*W +: W];
            b_d = sub ? ~req_b[gnt*W +: W] : req_b[gnt*W +: W];
            carry_d = sub;
            idx_d = '0;
            id_d = gnt;
            rr_ptr_d = gnt == IW'(NREQ - 1) ? '0 : gnt + 1'b1;
            state_d = RUN;
        end
        if (state_q == RUN) begin
            add_a = a_q[idx_q*8 +: 8];
            add_b = b_q[idx_q*8 +: 8];
            add_cin = carry_q;
            sum_d[idx_q*8 +: 8] = add_sum;
            carry_d = add_cout;
            idx_d = idx_q + 1'b1;
            cout_d = last ? add_cout : cout_q;
            state_d = last ? DONE : RUN;
        end
        if (state_q == DONE && rsp_ready)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            id_q <= '0;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            idx_q <= '0;
            carry_q <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q <= id_d;
            a_q <= a_d;
            b_q <= b_d;
            sum_q <= sum_d;
            idx_q <= idx_d;
            carry_q <= carry_d;
            cout_q <= cout_d;
        end
    end

    assign rsp_valid = state_q == DONE;
    assign rsp_sum = sum_q;
    assign rsp_cout = cout_q;
    assign rsp_id = id_q;
endmodule

// File: tb/tb_fhe_add_sched.sv
// tb_fhe_add_sched: directed and random checks of fhe_add_sched against an arithmetic reference model.
module tb_fhe_add_sched;
    localparam int NREQ = 4, NBYTES = 4, W = 32;
    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0] req_valid = '0, req_ready, req_sub = '0;
    logic [NREQ*W-1:0] req_a = '0, req_b = '0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_cout, add_cin, add_cout;
    logic [W-1:0] rsp_sum;
    logic [1:0] rsp_id;
    logic [7:0] add_a, add_b, add_sum;
    int n_assert = 0, n_fail = 0, ptr = 0, cyc = 0, acc_t = 0, prev_t, g;
    int ids[$];
    int exp_ids[6] = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign {add_cout, add_sum} = add_a + add_b + add_cin;

    fhe_add_sched #(.NREQ(NREQ), .NBYTES(NBYTES)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
`ifdef FHE_ADD_SCHED_SUB_EN
        .req_sub(req_sub),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_id(rsp_id), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++)
            if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return 0;
    endfunction

    // One full operation: wait for grant, follow each byte, then hold DONE for dly cycles
    task automatic op(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] after, input int dly, output int gr);
        logic [W-1:0] a, bx, es;
        logic [63:0] m;
        logic c0, ec;
        int w, eg;
        w = 0;
        gr = -1;
        req_valid = mask;
        #1;
        while (req_ready == '0 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        eg = pick(mask);
        chk("grant", req_ready, 64'(NREQ'(1) << eg));
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gr = i;
        acc_t = cyc;
        c0 = req_sub[eg];
        a = req_a[eg*W +: W];
        bx = c0 ? ~req_b[eg*W +: W] : req_b[eg*W +: W];
        {ec, es} = {1'b0, a} + {1'b0, bx} + 33'(c0);
        ptr = (eg + 1) % NREQ;
        @(negedge clk);
        req_valid = after;
        #1;
        for (int k = 0; k < NBYTES; k++) begin
            m = (64'd1 << (8 * k)) - 64'd1;
            chk("add_a", add_a, 64'(a[k*8 +: 8]));
            chk("add_b", add_b, 64'(bx[k*8 +: 8]));
            chk("add_cin", add_cin, ((64'(a) & m) + (64'(bx) & m) + 64'(c0)) >> (8 * k));
            chk("run_ready", req_ready, 0);
            chk("run_valid", rsp_valid, 0);
            @(negedge clk);
            #1;
        end
        chk("latency", cyc - acc_t, NBYTES + 1);
        for (int d = 0; d <= dly; d++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_sum", rsp_sum, 64'(es));
            chk("rsp_cout", rsp_cout, 64'(ec));
            chk("rsp_id", rsp_id, 64'(eg));
            chk("done_ready", req_ready, 0);
            chk("done_idle_adder", {add_a, add_b, add_cin}, 0);
            if (d == dly) rsp_ready = 1'b1;
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b0;
        chk("idle_valid", rsp_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_adder", {add_a, add_b, add_cin}, 0);
        chk("rst_rsp", {rsp_sum, rsp_cout, rsp_id}, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        req_a[0 +: W] = 32'h0000_00FF;
        req_b[0 +: W] = 32'h0000_0001;
        op(4'b0001, 4'b0000, 0, g);
        req_a[2*W +: W] = 32'hFFFF_FFFF;
        req_b[2*W +: W] = 32'h0000_0001;
        op(4'b0100, 4'b0000, 0, g);
        req_a[W +: W] = 32'h1234_5678;
        req_b[W +: W] = 32'h8765_4321;
        op(4'b0001, 4'b0010, 10, g);
        chk("req1_after_release", req_ready, 4'b0010);
        op(4'b0010, 4'b0000, 0, g);
        req_valid = 4'b0010;
        #1;
        chk("pre_rst_grant", req_ready, 64'(NREQ'(1) << pick(4'b0010)));
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrun_rst_valid", rsp_valid, 0);
        chk("midrun_rst_ready", req_ready, 0);
        chk("midrun_rst_adder", {add_a, add_b, add_cin}, 0);
        chk("midrun_rst_rsp", {rsp_sum, rsp_cout, rsp_id}, 0);
        @(negedge clk);
        rst = 1'b0;
        ptr = 0;
        #1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = $urandom;
            req_b[i*W +: W] = $urandom;
        end
        for (int i = 0; i < 6; i++) begin
            prev_t = acc_t;
            op(4'b1111, 4'b1111, 0, g);
            ids.push_back(g);
            if (i > 0) chk("accept_spacing", acc_t - prev_t, NBYTES + 2);
        end
        req_valid = '0;
        for (int i = 0; i < 6; i++) chk("rr_order", ids[i], exp_ids[i]);
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*W +: W] = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom;
                req_b[i*W +: W] = $urandom;
            end
            op(NREQ'($urandom_range(1, 15)), 4'b0000, $urandom_range(0, 3), g);
        end
`ifdef FHE_ADD_SCHED_SUB_EN
        req_sub = 4'b1111;
        req_a[0 +: W] = 32'd5;
        req_b[0 +: W] = 32'd7;
        op(4'b0001, 4'b0000, 0, g);
        req_a[3*W +: W] = 32'd7;
        req_b[3*W +: W] = 32'd5;
        op(4'b1000, 4'b0000, 0, g);
        req_sub = '0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
